// File: rtl/mux_pkg.sv
// Shared helpers for the stream multiplexer: index width and one-hot decode.
package mux_pkg;

    localparam int unsigned MaxN = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Out-of-range indices decode to all zeros, so they never produce a candidate.
    function automatic logic [MaxN-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MaxN-1:0] v;
        v = '0;
        if (idx < n && idx < MaxN) begin
            v = {{(MaxN-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin when ROUND_ROBIN_EN is defined, otherwise fixed
// lowest-index priority with no pointer state.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned SEL_W = clog2(N);

`ifdef ROUND_ROBIN_EN

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] gnt_idx;
    logic             found;

    // Two passes: first the slots at or above the pointer, then wrap to the bottom.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= 32'(ptr_q))) begin
                grant[i] = 1'b1;
                gnt_idx  = SEL_W'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                gnt_idx  = SEL_W'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (32'(gnt_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`else

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Fixed priority is stateless; these inputs exist only for port compatibility.
    logic unused_inputs;
    assign unused_inputs = ^{Clk, Reset, advance};

`endif

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N-to-1 valid/ready stream multiplexer with optional forced select.
// Arbitration policy is chosen by ROUND_ROBIN_EN (see rr_arbiter).
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  N     = 4,
    localparam int unsigned SEL_W = clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic             load;
    logic             xfer;
    logic             advance;
    logic [N-1:0]     force_mask;
    logic [N-1:0]     cand;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] gnt_idx;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    always_comb begin
        load       = ~out_valid_q | out_ready;
        force_mask = N'(onehot(32'(force_sel), N));
        cand       = force_en ? (in_valid & force_mask) : in_valid;
        in_ready   = Reset ? '0 : (grant & {N{load}});
        xfer       = |in_ready;
        // A forced grant must not disturb the round-robin position.
        advance    = xfer & ~force_en;
    end

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (cand),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        gnt_data = '0;
        gnt_idx  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_idx  = SEL_W'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = gnt_data;
                out_sel_d   = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: cycle-level reference model plus directed literal checks.
module tb_stream_mux_arb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 2;

    logic                 Clk;
    logic                 Reset;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 force_en;
    logic [SEL_W-1:0]     force_sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_ready;

    int n_cmp;
    int n_fail;

    stream_mux_arb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the output slot as a one-entry buffer, arbitration by scanning
    // channels in priority order from the current fairness position.
    bit          m_known;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;

    always @(negedge Clk) begin
        bit       ld;
        bit       got;
        int       win;
        int       c;
        bit [3:0] cnd;
        bit [3:0] exp_rdy;

        ld      = !m_valid || out_ready;
        cnd     = in_valid;
        if (force_en) begin
            cnd = 4'b0;
            if (int'(force_sel) < N) cnd[force_sel] = in_valid[force_sel];
        end
        got = 1'b0;
        win = 0;
        for (int k = 0; k < N; k++) begin
`ifdef ROUND_ROBIN_EN
            c = (m_ptr + k) % N;
`else
            c = k;
`endif
            if (!got && cnd[c]) begin
                got = 1'b1;
                win = c;
            end
        end
        exp_rdy = 4'b0;
        if (!Reset && ld && got) exp_rdy[win] = 1'b1;

        if (m_known) begin
            check("model in_ready", 64'(in_ready), 64'(exp_rdy));
            check("model out_valid", 64'(out_valid), 64'(m_valid));
            check("model out_data", 64'(out_data), 64'(m_data));
            check("model out_sel", 64'(out_sel), 64'(m_sel));
        end

        if (Reset) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = 32'h0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (ld) begin
            if (got) begin
                m_valid = 1'b1;
                m_data  = in_data[win*WIDTH +: WIDTH];
                m_sel   = win;
                if (!force_en) m_ptr = (win + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input logic [15:0] tag);
        for (int i = 0; i < N; i++) begin
            in_data[i*WIDTH +: WIDTH] = {tag, 16'(i)};
        end
    endtask

    initial begin
        int exp_sel;

        n_cmp     = 0;
        n_fail    = 0;
        m_known   = 1'b0;
        m_valid   = 1'b0;
        m_data    = 32'h0;
        m_sel     = 0;
        m_ptr     = 0;
        Reset     = 1'b1;
        in_valid  = 4'b1111;
        in_data   = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b0;
        set_data(16'h1111);

        // T1: reset with every channel valid
        step();
        step();
        check("T1 out_valid", 64'(out_valid), 64'd0);
        check("T1 out_data", 64'(out_data), 64'd0);
        check("T1 out_sel", 64'(out_sel), 64'd0);
        check("T1 in_ready", 64'(in_ready), 64'd0);

        // T2: single channel streaming
        Reset     = 1'b0;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        set_data(16'hA5A5);
        settle();
        check("T2 in_ready", 64'(in_ready), 64'b0100);
        step();
        in_valid = 4'b0000;
        check("T2 out_valid", 64'(out_valid), 64'd1);
        check("T2 out_data", 64'(out_data), 64'hA5A5_0002);
        check("T2 out_sel", 64'(out_sel), 64'd2);

        // T3: stall holds data and blocks every input
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        set_data(16'h3333);
        settle();
        check("T3 in_ready stall", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("T3 in_ready held", 64'(in_ready), 64'd0);
            check("T3 out_data held", 64'(out_data), 64'hA5A5_0002);
        end
        out_ready = 1'b1;
        settle();
        check("T3 release in_ready", 64'(in_ready), 64'b0001);
        step();
        in_valid = 4'b0000;
        check("T3 new out_data", 64'(out_data), 64'h3333_0000);
        check("T3 new out_sel", 64'(out_sel), 64'd0);
        step();
        check("T3 single beat", 64'(out_valid), 64'd0);

        // T6: reset while a beat is stalled in the output register
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        set_data(16'h6666);
        step();
        in_valid = 4'b0000;
        check("T6 loaded valid", 64'(out_valid), 64'd1);
        check("T6 loaded sel", 64'(out_sel), 64'd1);
        step();
        Reset = 1'b1;
        step();
        check("T6 dropped", 64'(out_valid), 64'd0);
        check("T6 data cleared", 64'(out_data), 64'd0);
        Reset     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(16'h4444);
        settle();
        check("T6 first grant ch0", 64'(in_ready), 64'b0001);

        // T4: fairness with all channels valid
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef ROUND_ROBIN_EN
            exp_sel = k % 4;
`else
            exp_sel = 0;
`endif
            check("T4 out_sel", 64'(out_sel), 64'(exp_sel));
            check("T4 out_valid", 64'(out_valid), 64'd1);
        end

        // T5: forced select
        force_en  = 1'b1;
        force_sel = 2'd3;
        set_data(16'h5555);
        settle();
        check("T5 in_ready", 64'(in_ready), 64'b1000);
        step();
        check("T5 out_sel", 64'(out_sel), 64'd3);
        check("T5 out_data", 64'(out_data), 64'h5555_0003);
        in_valid = 4'b0111;
        settle();
        check("T5 no grant", 64'(in_ready), 64'd0);
        step();
        check("T5 out_valid", 64'(out_valid), 64'd0);

        force_en = 1'b0;
        in_valid = 4'b0000;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
